axi_master_if: RTL and testbench

//  AXI4 initiator (write+read) that drives the AXI-to-SRAM slave from a local command port.
//  One command at a time: a single INCR burst, either write (AW->W->B) or read (AR->R).

---
 rtl/axi_master_if.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_master_if.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_if.sv
// AXI4 initiator: one INCR burst per local command, write (AW->W->B) or read (AR->R).
// Define AXI_MST_LAST_CHK_EN to count read beats and flag RLAST mismatches on done_err.
module axi_master_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ADDR = 3'd1,
        S_W_DATA = 3'd2,
        S_W_RESP = 3'd3,
        S_R_ADDR = 3'd4,
        S_R_DATA = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [7:0]            r_cnt;
    logic                  r_awvalid;
    logic                  r_arvalid;
    logic                  r_done;
    logic [1:0]            r_done_resp;
    logic                  r_done_err;
    logic [1:0]            r_resp_acc;
`ifdef AXI_MST_LAST_CHK_EN
    logic                  r_last_err;
`endif

    logic       w_in_wdata;
    logic       w_in_rdata;
    logic       w_cmd_ready;
    logic       w_w_hs;
    logic       w_w_last;
    logic       w_r_hs;
    logic [1:0] w_resp_next;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        resp_max = (a > b) ? a : b;
    endfunction

    assign w_in_wdata  = (r_state == S_W_DATA);
    assign w_in_rdata  = (r_state == S_R_DATA);
    // Held low during the done cycle so a new command starts only after done is seen.
    assign w_cmd_ready = (r_state == S_IDLE) && !r_done;
    assign w_w_last    = (r_cnt == r_len);
    assign w_w_hs      = w_in_wdata && wr_valid && WREADY;
    assign w_r_hs      = w_in_rdata && RVALID && rd_ready;
    assign w_resp_next = resp_max(r_resp_acc, RRESP);

    assign cmd_ready = w_cmd_ready;
    assign AWADDR    = r_addr;
    assign AWLEN     = r_len;
    assign AWSIZE    = r_size;
    assign AWBURST   = 2'b01;
    assign AWVALID   = r_awvalid;
    assign ARADDR    = r_addr;
    assign ARLEN     = r_len;
    assign ARSIZE    = r_size;
    assign ARBURST   = 2'b01;
    assign ARVALID   = r_arvalid;
    assign WVALID    = w_in_wdata && wr_valid;
    assign wr_ready  = w_in_wdata && WREADY;
    assign WDATA     = wr_data;
    assign WSTRB     = wr_strb;
    assign WLAST     = w_in_wdata && w_w_last;
    assign BREADY    = (r_state == S_W_RESP);
    assign rd_valid  = w_in_rdata && RVALID;
    assign RREADY    = w_in_rdata && rd_ready;
    assign rd_data   = RDATA;
    assign rd_last   = w_in_rdata && RLAST;
    assign done      = r_done;
    assign done_resp = r_done_resp;
    assign done_err  = r_done_err;

    // Command sequencer: accepts a command, runs the address, data and response phases.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= 8'd0;
            r_size      <= 3'd0;
            r_cnt       <= 8'd0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_done      <= 1'b0;
            r_done_resp <= 2'b00;
            r_done_err  <= 1'b0;
            r_resp_acc  <= 2'b00;
`ifdef AXI_MST_LAST_CHK_EN
            r_last_err  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && w_cmd_ready) begin
                        r_addr     <= cmd_addr;
                        r_len      <= cmd_len;
                        r_size     <= cmd_size;
                        r_cnt      <= 8'd0;
                        r_resp_acc <= 2'b00;
`ifdef AXI_MST_LAST_CHK_EN
                        r_last_err <= 1'b0;
`endif
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= S_W_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_R_ADDR;
                        end
                    end
                end
                S_W_ADDR: begin
                    if (AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_W_DATA;
                    end
                end
                S_W_DATA: begin
                    if (w_w_hs) begin
                        if (w_w_last) begin
                            r_state <= S_W_RESP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_W_RESP: begin
                    if (BVALID) begin
                        r_done      <= 1'b1;
                        r_done_resp <= BRESP;
                        r_done_err  <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_R_ADDR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_R_DATA;
                    end
                end
                S_R_DATA: begin
                    if (w_r_hs) begin
                        r_resp_acc <= w_resp_next;
`ifdef AXI_MST_LAST_CHK_EN
                        r_cnt <= r_cnt + 8'd1;
                        // Missing RLAST on the final counted beat is remembered until the real RLAST.
                        if ((r_cnt == r_len) && !RLAST) begin
                            r_last_err <= 1'b1;
                        end
`endif
                        if (RLAST) begin
                            r_done      <= 1'b1;
                            r_done_resp <= w_resp_next;
`ifdef AXI_MST_LAST_CHK_EN
                            r_done_err  <= r_last_err || (r_cnt != r_len);
`else
                            r_done_err  <= 1'b0;
`endif
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_if.sv
// Self-checking bench for axi_master_if: models the AXI slave and the local streams,
// scoreboards beat data in queues and checks responses, timing and reset behaviour.
module tb_axi_master_if;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          done, done_err;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic [1:0]    AWBURST, ARBURST;
    logic          AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST, WVALID, WREADY;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY;
    logic          RLAST, RVALID, RREADY;

    int checks = 0;
    int errors = 0;

    axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0; cmd_size = 3'd0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready);
        end
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input string name, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [63:0] dbase, input logic [7:0] strb,
                             input logic [1:0] bresp, input int aw_delay, input bit gappy);
        logic [63:0] exp_q[$];
        logic [63:0] exp_d;
        int awcnt = 0, wsent = 0, wseen = 0;
        bit bhs = 1'b0, got_done = 1'b0;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(dbase + 64'(i));
        issue_cmd(1'b1, addr, len, size);
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            AWREADY  = AWVALID && (awcnt == aw_delay);
            wr_valid = (wsent <= int'(len)) && (!gappy || ($urandom_range(0, 2) != 0));
            wr_data  = dbase + 64'(wsent);
            wr_strb  = strb;
            WREADY   = !gappy || (cyc % 2 == 0);
            BVALID   = (wseen > int'(len)) && !bhs;
            BRESP    = bresp;
            #1;
            if (cyc == 0) begin
                checks++;
                if (AWVALID !== 1'b1) begin
                    errors++; $display("FAIL %s awvalid_n1 got %b exp 1", name, AWVALID);
                end
            end
            if (AWVALID) begin
                awcnt++;
                checks++;
                if ({AWADDR, AWLEN, AWSIZE, AWBURST} !== {addr, len, size, 2'b01}) begin
                    errors++;
                    $display("FAIL %s aw_fields got %h/%h/%h/%h exp %h/%h/%h/1", name,
                             AWADDR, AWLEN, AWSIZE, AWBURST, addr, len, size);
                end
                checks++;
                if (WVALID !== 1'b0) begin
                    errors++; $display("FAIL %s w_before_aw got WVALID=%b exp 0", name, WVALID);
                end
            end
            if (wr_valid && wr_ready) wsent++;
            if (WVALID && WREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s extra_w_beat got %h exp none", name, WDATA);
                end else begin
                    exp_d = exp_q.pop_front();
                    if ({WDATA, WSTRB, WLAST} !== {exp_d, strb, 1'(wseen == int'(len))}) begin
                        errors++;
                        $display("FAIL %s w_beat%0d got %h/%h/%b exp %h/%h/%b", name, wseen,
                                 WDATA, WSTRB, WLAST, exp_d, strb, wseen == int'(len));
                    end
                end
                wseen++;
            end
            if (BVALID && BREADY) bhs = 1'b1;
            if (done) begin
                checks++;
                if (done_resp !== bresp || done_err !== 1'b0 || !bhs) begin
                    errors++;
                    $display("FAIL %s done got resp=%b err=%b b_hs=%b exp resp=%b err=0 b_hs=1",
                             name, done_resp, done_err, bhs, bresp);
                end
                got_done = 1'b1;
            end
            step;
        end
        idle_inputs;
        if (!got_done) begin
            errors++; $display("FAIL %s timeout got no done exp done", name);
        end
        checks++;
        if (wseen != int'(len) + 1 || awcnt != aw_delay + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s counts got w=%0d aw=%0d left=%0d exp w=%0d aw=%0d left=0", name,
                     wseen, awcnt, exp_q.size(), int'(len) + 1, aw_delay + 1);
        end
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s after_done got ready=%b done=%b exp 1/0", name, cmd_ready, done);
        end
    endtask

    task automatic run_read(input string name, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [63:0] dbase, input int bad_idx,
                            input int rlast_idx, input bit gappy);
        logic [63:0] exp_q[$];
        logic [63:0] exp_d;
        logic [1:0]  exp_resp = 2'b00;
        logic        exp_err;
        int arcnt = 0, rsent = 0, rseen = 0;
        bit arhs = 1'b0, ended = 1'b0, active, got_done = 1'b0;
`ifdef AXI_MST_LAST_CHK_EN
        exp_err = (rlast_idx != int'(len));
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i <= rlast_idx; i++) begin
            exp_q.push_back(dbase + 64'(i));
            if (i == bad_idx) exp_resp = 2'b10;
        end
        issue_cmd(1'b0, addr, len, size);
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            active   = arhs && !ended;
            ARREADY  = ARVALID && (arcnt == 1);
            RVALID   = active;
            RDATA    = dbase + 64'(rsent);
            RRESP    = (rsent == bad_idx) ? 2'b10 : 2'b00;
            RLAST    = (rsent == rlast_idx);
            rd_ready = !gappy || (cyc % 2 == 1);
            #1;
            if (ARVALID) begin
                arcnt++;
                checks++;
                if ({ARADDR, ARLEN, ARSIZE, ARBURST} !== {addr, len, size, 2'b01}) begin
                    errors++;
                    $display("FAIL %s ar_fields got %h/%h/%h/%h exp %h/%h/%h/1", name,
                             ARADDR, ARLEN, ARSIZE, ARBURST, addr, len, size);
                end
                if (ARREADY) arhs = 1'b1;
            end
            if (active) begin
                checks++;
                if (RREADY !== rd_ready || rd_valid !== RVALID) begin
                    errors++;
                    $display("FAIL %s r_mirror got RREADY=%b rd_valid=%b exp %b/%b", name,
                             RREADY, rd_valid, rd_ready, RVALID);
                end
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s extra_r_beat got %h exp none", name, rd_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if ({rd_data, rd_last} !== {exp_d, 1'(rseen == rlast_idx)}) begin
                        errors++;
                        $display("FAIL %s r_beat%0d got %h/%b exp %h/%b", name, rseen,
                                 rd_data, rd_last, exp_d, rseen == rlast_idx);
                    end
                end
                rseen++;
            end
            if (RVALID && RREADY) begin
                if (RLAST) ended = 1'b1;
                rsent++;
            end
            if (done) begin
                checks++;
                if (done_resp !== exp_resp || done_err !== exp_err || !ended) begin
                    errors++;
                    $display("FAIL %s done got resp=%b err=%b ended=%b exp resp=%b err=%b ended=1",
                             name, done_resp, done_err, ended, exp_resp, exp_err);
                end
                got_done = 1'b1;
            end
            step;
        end
        idle_inputs;
        if (!got_done) begin
            errors++; $display("FAIL %s timeout got no done exp done", name);
        end
        checks++;
        if (rseen != rlast_idx + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s counts got r=%0d left=%0d exp r=%0d left=0", name, rseen,
                     exp_q.size(), rlast_idx + 1);
        end
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s after_done got ready=%b done=%b exp 1/0", name, cmd_ready, done);
        end
    endtask

    task automatic test_reset;
        idle_inputs;
        ARESET = 1'b1;
        step; step;
        ARESET = 1'b0;
        #1;
        checks++;
        if ({AWVALID, ARVALID, done, done_err, done_resp} !== 5'b0) begin
            errors++;
            $display("FAIL reset_regs got aw=%b ar=%b done=%b err=%b resp=%b exp all 0",
                     AWVALID, ARVALID, done, done_err, done_resp);
        end
        checks++;
        if ({cmd_ready, wr_ready, RREADY, BREADY} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_handshake got %b exp 1000", {cmd_ready, wr_ready, RREADY, BREADY});
        end
        step;
    endtask

    task automatic test_write_single;
        run_write("wr_len0", 32'h0000_0010, 8'd0, 3'd2, 64'h0000_0000_AABB_CCDD, 8'h0F, 2'b00, 3, 1'b0);
    endtask

    task automatic test_write_burst;
        run_write("wr_len3_gaps", 32'h0000_0100, 8'd3, 3'd3, 64'h1111_2222_0000_0000, 8'hFF, 2'b00, 0, 1'b1);
    endtask

    task automatic test_read_burst;
        run_read("rd_len3", 32'h0000_8000, 8'd3, 3'd3, 64'hD00D_0000_0000_0000, -1, 3, 1'b1);
    endtask

    task automatic test_resp;
        run_write("wr_bresp10", 32'h0000_0200, 8'd1, 3'd3, 64'h5555_0000_0000_0000, 8'hFF, 2'b10, 1, 1'b0);
        run_read("rd_rresp10", 32'h0000_0300, 8'd3, 3'd3, 64'h7777_0000_0000_0000, 1, 3, 1'b0);
    endtask

    task automatic test_reset_mid;
        int wseen = 0;
        issue_cmd(1'b1, 32'h0000_0400, 8'd3, 3'd3);
        for (int cyc = 0; cyc < 100 && wseen < 2; cyc++) begin
            AWREADY  = AWVALID;
            wr_valid = 1'b1;
            wr_data  = 64'hCAFE_0000_0000_0000 + 64'(wseen);
            wr_strb  = 8'hFF;
            WREADY   = 1'b1;
            #1;
            if (WVALID && WREADY) wseen++;
            if (wseen < 2) step;
        end
        if (wseen < 2) begin
            errors++; $display("FAIL rst_mid timeout got %0d beats exp 2", wseen);
        end
        ARESET = 1'b1;
        step;
        ARESET = 1'b0;
        #1;
        checks++;
        if ({WVALID, AWVALID, cmd_ready, wr_ready, BREADY, RREADY, done} !== 7'b0010000) begin
            errors++;
            $display("FAIL rst_mid got wv=%b awv=%b crdy=%b wrdy=%b brdy=%b rrdy=%b done=%b exp 0010000",
                     WVALID, AWVALID, cmd_ready, wr_ready, BREADY, RREADY, done);
        end
        idle_inputs;
        step;
        run_read("rd_after_rst", 32'h0000_0500, 8'd1, 3'd3, 64'hBEEF_0000_0000_0000, -1, 1, 1'b0);
    endtask

    task automatic test_last_chk;
        run_read("rd_early_rlast", 32'h0000_0600, 8'd3, 3'd3, 64'h9999_0000_0000_0000, -1, 2, 1'b0);
        run_read("rd_late_rlast", 32'h0000_0700, 8'd1, 3'd3, 64'h8888_0000_0000_0000, -1, 3, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_write("b2b_wr", 32'h0000_0800, 8'd2, 3'd3, 64'h4444_0000_0000_0000, 8'h3C, 2'b01, 0, 1'b0);
        run_read("b2b_rd", 32'h0000_0800, 8'd2, 3'd3, 64'h4444_0000_0000_0000, 2, 2, 1'b1);
    endtask

    task automatic test_len255;
        run_write("wr_len255", 32'h0001_0000, 8'd255, 3'd3, 64'h0F0F_0000_0000_0000, 8'hFF, 2'b00, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_write_single;
        test_write_burst;
        test_read_burst;
        test_resp;
        test_reset_mid;
        test_last_chk;
        test_back_to_back;
        test_len255;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
